// File: rtl/output_buffer_pkd.sv
// Row-organised result buffer: vector rows, scalar packing, and a registered valid/ready read port.
// Optional partial-sum accumulation on commit is enabled by defining OUTPUT_BUFFER_ACCUM_EN.
module output_buffer_pkd #(
  parameter int DATA_W    = 32,
  parameter int LANES     = 16,
  parameter int NUM_BANKS = 4,
  parameter int DEPTH     = 32,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic                              is_scalar,
  input  logic [AW-1:0]                     wr_addr,
  input  logic [NUM_BANKS*LANES*DATA_W-1:0] wr_data,
  input  logic [NUM_BANKS*DATA_W-1:0]       wr_scalar,
  input  logic                              flush,
`ifdef OUTPUT_BUFFER_ACCUM_EN
  input  logic                              acc_en,
`endif
  input  logic                              rd_req,
  input  logic [AW-1:0]                     rd_addr,
  input  logic                              rd_ready,
  output logic                              rd_valid,
  output logic [NUM_BANKS*LANES*DATA_W-1:0] rd_data,
  output logic [$clog2(LANES+1)-1:0]        pack_cnt,
  output logic                              busy
);

  localparam int ROW_W = NUM_BANKS * LANES * DATA_W;
  localparam int CW    = $clog2(LANES + 1);

  typedef enum logic {IDLE, PACK} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     row_addr_q, row_addr_d;
  logic [CW-1:0]     cur_lane;
  logic              scalar_beat, vector_beat;
  logic              commit, commit_vec;
  logic [AW-1:0]     commit_addr;
  logic [ROW_W-1:0]  commit_row;
  logic [ROW_W-1:0]  pack_buf;
  logic [ROW_W-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  row_vld;
  logic              rd_accept;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

`ifdef OUTPUT_BUFFER_ACCUM_EN
  logic [ROW_W-1:0] old_row;

  // Unfilled lanes keep the stored sum when accumulating, else they clear.
  function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic keep, input logic acc);
    if (!acc) return keep ? new_w : '0;
    if (!keep) return old_w;
    return old_w + new_w;
  endfunction

  assign old_row = (addr_ok(commit_addr) && row_vld[commit_addr]) ? mem[commit_addr] : '0;
`else
  function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] new_w,
                                                   input logic keep);
    return keep ? new_w : '0;
  endfunction
`endif

  assign wr_ready    = !((state_q == PACK) && !is_scalar);
  assign scalar_beat = wr_valid && wr_ready && is_scalar;
  assign vector_beat = wr_valid && wr_ready && !is_scalar;
  assign cur_lane    = (state_q == PACK) ? cnt_q : '0;
  assign pack_cnt    = cnt_q;
  assign busy        = (state_q == PACK);
  assign rd_accept   = rd_req && (!rd_valid || rd_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      row_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_addr_q <= row_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_addr_d  = row_addr_q;
    commit      = 1'b0;
    commit_vec  = 1'b0;
    commit_addr = wr_addr;
    case (state_q)
      IDLE: begin
        if (vector_beat) begin
          commit     = 1'b1;
          commit_vec = 1'b1;
        end else if (scalar_beat) begin
          row_addr_d = wr_addr;
          if (LANES == 1 || flush) begin
            commit = 1'b1;
          end else begin
            state_d = PACK;
            cnt_d   = CW'(1);
          end
        end
      end
      PACK: begin
        commit_addr = row_addr_q;
        if ((scalar_beat && int'(cnt_q) == LANES - 1) || flush) begin
          commit  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (scalar_beat) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Assemble the committed row: packed lanes, then the current beat, then zero fill.
  always_comb begin
    commit_row = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int l = 0; l < LANES; l++) begin
        logic [DATA_W-1:0] new_w;
        logic              keep;
        new_w = '0;
        keep  = 1'b0;
        if (commit_vec) begin
          new_w = wr_data[(b*LANES+l)*DATA_W +: DATA_W];
          keep  = 1'b1;
        end else if (l < int'(cur_lane)) begin
          new_w = pack_buf[(b*LANES+l)*DATA_W +: DATA_W];
          keep  = 1'b1;
        end else if (l == int'(cur_lane) && scalar_beat) begin
          new_w = wr_scalar[b*DATA_W +: DATA_W];
          keep  = 1'b1;
        end
`ifdef OUTPUT_BUFFER_ACCUM_EN
        commit_row[(b*LANES+l)*DATA_W +: DATA_W] =
          merge_word(old_row[(b*LANES+l)*DATA_W +: DATA_W], new_w, keep, acc_en);
`else
        commit_row[(b*LANES+l)*DATA_W +: DATA_W] = merge_word(new_w, keep);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (scalar_beat) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int l = 0; l < LANES; l++) begin
          if (l == int'(cur_lane)) begin
            pack_buf[(b*LANES+l)*DATA_W +: DATA_W] <= wr_scalar[b*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Storage: row_vld masks stale contents so reset clears every row at once.
  always_ff @(posedge clk) begin
    if (commit && addr_ok(commit_addr)) mem[commit_addr] <= commit_row;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_vld <= '0;
    end else if (commit && addr_ok(commit_addr)) begin
      row_vld[commit_addr] <= 1'b1;
    end
  end

  // Read stage: sampled before this edge's commit, giving read-before-write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rd_accept) begin
      rd_valid <= 1'b1;
      rd_data  <= (addr_ok(rd_addr) && row_vld[rd_addr]) ? mem[rd_addr] : '0;
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_output_buffer_pkd.sv
// Directed bench for output_buffer_pkd: table-driven scalar packing plus hand-written sequences.
module tb_output_buffer_pkd;

  localparam int DW = 32;
  localparam int L  = 16;
  localparam int NB = 4;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int RW = NB * L * DW;
  localparam int CW = $clog2(L + 1);

  logic          clk, rst;
  logic          wr_valid, wr_ready, is_scalar, flush;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [RW-1:0] wr_data, rd_data;
  logic [NB*DW-1:0] wr_scalar;
  logic          rd_req, rd_ready, rd_valid, busy;
  logic [CW-1:0] pack_cnt;
`ifdef OUTPUT_BUFFER_ACCUM_EN
  logic          acc_en;
`endif

  int total = 0;
  int bad   = 0;

  output_buffer_pkd #(.DATA_W(DW), .LANES(L), .NUM_BANKS(NB), .DEPTH(D), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .is_scalar(is_scalar),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_scalar(wr_scalar), .flush(flush),
`ifdef OUTPUT_BUFFER_ACCUM_EN
    .acc_en(acc_en),
`endif
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .pack_cnt(pack_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    int            beat;
    int            kind;
    int            exp_cnt;
    logic          exp_busy;
  } beat_t;

  beat_t tbl [21];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    int idx;
    idx = -1;
    total++;
    for (int i = 0; i < NB * L; i++)
      if (idx < 0 && act[i*DW +: DW] !== exp[i*DW +: DW]) idx = i;
    if (idx >= 0) begin
      bad++;
      $display("FAIL %s: word %0d got %0h want %0h", name, idx, act[idx*DW +: DW], exp[idx*DW +: DW]);
    end
  endtask

  // Expected row contents, word(b,l) computed from the documented stimulus formulas.
  function automatic logic [RW-1:0] mk_row(input int kind);
    logic [RW-1:0] r;
    r = '0;
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < L; l++) begin
        logic [DW-1:0] w;
        case (kind)
          0: w = DW'(b * 16 + l);
          1: w = DW'(100 * b + l);
          2: w = (l < 5) ? DW'(50 * b + l + 7) : '0;
          3: w = DW'(32'hA000 + b * 256 + l);
          4: w = 32'hFFFF_FFFF;
          5: w = 32'h2;
          6: w = 32'h1;
          default: w = '0;
        endcase
        r[(b*L+l)*DW +: DW] = w;
      end
    return r;
  endfunction

  function automatic logic [NB*DW-1:0] mk_scalar(input int kind, input int beat);
    logic [NB*DW-1:0] s;
    for (int b = 0; b < NB; b++)
      s[b*DW +: DW] = (kind == 1) ? DW'(100 * b + beat) : DW'(50 * b + beat + 7);
    return s;
  endfunction

  task automatic read_row(input logic [AW-1:0] a);
    rd_req = 1'b1; rd_addr = a; rd_ready = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr_valid = 1'b0; is_scalar = 1'b0; flush = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_scalar = '0;
    rd_req = 1'b0; rd_ready = 1'b1;
`ifdef OUTPUT_BUFFER_ACCUM_EN
    acc_en = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{addr: (i == 0) ? AW'(9) : AW'(20), beat: i, kind: 1,
                 exp_cnt: (i + 1) % 16, exp_busy: (i < 15)};
    end
    for (int i = 0; i < 5; i++) begin
      tbl[16+i] = '{addr: (i == 0) ? AW'(3) : AW'(9), beat: i, kind: 2,
                    exp_cnt: i + 1, exp_busy: 1'b1};
    end

    step(); step();
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_pack_cnt", 64'(pack_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    rst = 1'b1;
    step();

    rd_req = 1'b1; rd_addr = 0;
    #1 chk("rd0_not_yet_valid", 64'(rd_valid), 64'd0);
    step();
    chk("rd0_valid", 64'(rd_valid), 64'd1);
    chk_row("rd0_zero", rd_data, '0);
    rd_addr = 31;
    step();
    rd_req = 1'b0;
    chk("rd31_valid", 64'(rd_valid), 64'd1);
    chk_row("rd31_zero", rd_data, '0);
    step();
    chk("rd_valid_drop", 64'(rd_valid), 64'd0);

    // Vector write to row 5 with a same-cycle read of row 5.
    wr_valid = 1'b1; is_scalar = 1'b0; wr_addr = 5; wr_data = mk_row(0);
    rd_req = 1'b1; rd_addr = 5;
    step();
    wr_valid = 1'b0; rd_req = 1'b0;
    chk_row("rbw_row5_old", rd_data, '0);
    read_row(5);
    chk_row("row5_pattern", rd_data, mk_row(0));

    // Scalar packing: row 9 complete, row 3 partial.
    for (int i = 0; i < 21; i++) begin
      wr_valid = 1'b1; is_scalar = 1'b1; wr_addr = tbl[i].addr;
      wr_scalar = mk_scalar(tbl[i].kind, tbl[i].beat);
      #1 chk($sformatf("tbl%0d_wr_ready", i), 64'(wr_ready), 64'd1);
      step();
      chk($sformatf("tbl%0d_pack_cnt", i), 64'(pack_cnt), 64'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].exp_busy));
    end

    // Vector beat stalls behind the partial row until flush retires it.
    is_scalar = 1'b0; wr_addr = 7; wr_data = mk_row(3);
    #1 chk("vec_blocked", 64'(wr_ready), 64'd0);
    step();
    chk("vec_blocked_busy", 64'(busy), 64'd1);
    chk("vec_blocked_ready", 64'(wr_ready), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_pack_cnt", 64'(pack_cnt), 64'd0);
    chk("after_flush_ready", 64'(wr_ready), 64'd1);
    step();
    wr_valid = 1'b0;
    read_row(9);
    chk_row("row9_scalar", rd_data, mk_row(1));
    read_row(3);
    chk_row("row3_flush", rd_data, mk_row(2));
    read_row(7);
    chk_row("row7_vec_after_flush", rd_data, mk_row(3));
    step();

    // Read backpressure, then back-to-back rows.
    rd_req = 1'b1; rd_addr = 5; rd_ready = 1'b0;
    step();
    rd_addr = 9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d_valid", i), 64'(rd_valid), 64'd1);
      chk_row($sformatf("stall%0d_data", i), rd_data, mk_row(0));
    end
    rd_ready = 1'b1;
    step();
    chk_row("b2b_row9", rd_data, mk_row(1));
    rd_addr = 3;
    step();
    chk("b2b_row3_valid", 64'(rd_valid), 64'd1);
    chk_row("b2b_row3", rd_data, mk_row(2));
    rd_req = 1'b0;
    step();
    chk("b2b_drop", 64'(rd_valid), 64'd0);

    // Asynchronous reset in the middle of packing.
    wr_valid = 1'b1; is_scalar = 1'b1; wr_addr = 12; wr_scalar = mk_scalar(1, 0);
    step(); step(); step();
    wr_valid = 1'b0;
    chk("prereset_cnt", 64'(pack_cnt), 64'd3);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_cnt", 64'(pack_cnt), 64'd0);
    step();
    rst = 1'b1;
    step();
    read_row(5);
    chk_row("cleared_row5", rd_data, '0);
    read_row(9);
    chk_row("cleared_row9", rd_data, '0);

`ifdef OUTPUT_BUFFER_ACCUM_EN
    wr_valid = 1'b1; is_scalar = 1'b0; wr_addr = 2; wr_data = mk_row(4); acc_en = 1'b0;
    step();
    wr_data = mk_row(5); acc_en = 1'b1;
    step();
    wr_valid = 1'b0; acc_en = 1'b0;
    read_row(2);
    chk_row("accum_wrap_row2", rd_data, mk_row(6));
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
